// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for the sequential ALU.
//   Request side : in_valid, in_ready, in_A, in_B, opcode
//   Response side: out_valid, out_ready, result, is_ovf
// The master modport belongs to the requester/consumer.
// The slave modport belongs to the ALU.
interface seq_alu_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        is_ovf;

  modport master (
    output in_valid, in_A, in_B, opcode, out_ready,
    input  in_ready, out_valid, result, is_ovf
  );

  modport slave (
    input  in_valid, in_A, in_B, opcode, out_ready,
    output in_ready, out_valid, result, is_ovf
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle, handshaked 16-bit signed ALU.
// Only one operation is in flight at a time.
// The opcode encoding and the result semantics match the combinational simpleALU.
// Multiply and shifts run iteratively, one step per clock.
//
// Ports:
//   clk  - system clock; all state changes on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - seq_alu_if.slave bundle, with these signals:
//            request : in_valid, in_ready, in_A, in_B, opcode
//            response: out_valid, out_ready, result, is_ovf
//
// Opcodes:
//   000 ADD   001 SUB   010 MUL
//   011 SLL   100 SRL   101 SLA   110 SRA
//   111 illegal (returns zero)
module seq_alu (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SLA = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  // Shift amount: in_B is taken as unsigned and saturated to 16.
  function automatic logic [4:0] sat_shamt(input logic [15:0] b);
    if (b >= 16'd16) begin
      sat_shamt = 5'd16;
    end else begin
      sat_shamt = b[4:0];
    end
  endfunction

  // Magnitude of a signed 16-bit value.
  // The result is 17 bits wide so that -32768 maps to +32768.
  function automatic logic [16:0] mag17(input logic [15:0] x);
    if (x[15]) begin
      mag17 = 17'd0 - {x[15], x};
    end else begin
      mag17 = {1'b0, x};
    end
  endfunction

  // Registered state
  state_t      state_r,     state_s;
  logic [2:0]  opcode_r,    opcode_s;
  logic [15:0] op_a_r,      op_a_s;
  logic [15:0] op_b_r,      op_b_s;
  logic [4:0]  cnt_r,       cnt_s;
  logic [31:0] acc_r,       acc_s;
  logic [31:0] mcand_r,     mcand_s;
  logic [16:0] mplier_r,    mplier_s;
  logic        neg_r,       neg_s;
  logic [15:0] shw_r,       shw_s;
  logic [31:0] result_r,    result_s;
  logic        is_ovf_r,    is_ovf_s;
  logic        in_ready_r,  in_ready_s;
  logic        out_valid_r, out_valid_s;

  // Combinational values for the final write of ADD/SUB
  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic        add_ovf_s;
  logic        sub_ovf_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.is_ovf    = is_ovf_r;

  // Exact 32-bit add/subtract of the sign-extended operands.
  // Overflow is judged on the 16-bit view of the result.
  always_comb begin
    sum_s     = {{16{op_a_r[15]}}, op_a_r} + {{16{op_b_r[15]}}, op_b_r};
    diff_s    = {{16{op_a_r[15]}}, op_a_r} - {{16{op_b_r[15]}}, op_b_r};
    add_ovf_s = (op_a_r[15] == op_b_r[15]) && (sum_s[15]  != op_a_r[15]);
    sub_ovf_s = (op_a_r[15] != op_b_r[15]) && (diff_s[15] != op_a_r[15]);
  end

  // Next-state and datapath update for the IDLE/EXEC/DONE controller
  always_comb begin
    state_s     = state_r;
    opcode_s    = opcode_r;
    op_a_s      = op_a_r;
    op_b_s      = op_b_r;
    cnt_s       = cnt_r;
    acc_s       = acc_r;
    mcand_s     = mcand_r;
    mplier_s    = mplier_r;
    neg_s       = neg_r;
    shw_s       = shw_r;
    result_s    = result_r;
    is_ovf_s    = is_ovf_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;

    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          opcode_s = bus.opcode;
          op_a_s   = bus.in_A;
          op_b_s   = bus.in_B;
          acc_s    = 32'd0;
          mcand_s  = {15'd0, mag17(bus.in_A)};
          mplier_s = mag17(bus.in_B);
          neg_s    = bus.in_A[15] ^ bus.in_B[15];
          shw_s    = bus.in_A;
          case (bus.opcode)
            OP_MUL:                         cnt_s = 5'd16;
            OP_SLL, OP_SRL, OP_SLA, OP_SRA: cnt_s = sat_shamt(bus.in_B);
            default:                        cnt_s = 5'd0;
          endcase
          state_s     = EXEC;
          in_ready_s  = 1'b0;
          out_valid_s = 1'b0;
        end else begin
          state_s    = IDLE;
          in_ready_s = 1'b1;
        end
      end

      EXEC: begin
        if (cnt_r == 5'd0) begin
          is_ovf_s = 1'b0;
          case (opcode_r)
            OP_ADD: begin
              result_s = sum_s;
              is_ovf_s = add_ovf_s;
            end
            OP_SUB: begin
              result_s = diff_s;
              is_ovf_s = sub_ovf_s;
            end
            OP_MUL: begin
              // Apply the product sign only at the end.
              // The shift-add loop works on magnitudes.
              if (neg_r) begin
                result_s = 32'd0 - acc_r;
              end else begin
                result_s = acc_r;
              end
            end
            OP_SLL, OP_SRL, OP_SLA, OP_SRA: result_s = {{16{shw_r[15]}}, shw_r};
            default:                        result_s = 32'd0;
          endcase
          state_s     = DONE;
          out_valid_s = 1'b1;
        end else begin
          case (opcode_r)
            OP_MUL: begin
              // One radix-2 step.
              // Add the multiplicand when the current multiplier bit is 1.
              // Then move on to the next bit.
              if (mplier_r[0]) begin
                acc_s = acc_r + mcand_r;
              end else begin
                acc_s = acc_r;
              end
              mcand_s  = {mcand_r[30:0], 1'b0};
              mplier_s = {1'b0, mplier_r[16:1]};
            end
            OP_SLL, OP_SLA: shw_s = {shw_r[14:0], 1'b0};
            OP_SRL:         shw_s = {1'b0, shw_r[15:1]};
            // The working register starts as A.
            // Its top bit therefore stays equal to the sign of A.
            OP_SRA:         shw_s = {shw_r[15], shw_r[15:1]};
            default:        shw_s = shw_r;
          endcase
          cnt_s = cnt_r - 5'd1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
        end else begin
          state_s     = DONE;
          out_valid_s = 1'b1;
        end
      end

      default: begin
        state_s     = IDLE;
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  // An asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      opcode_r    <= 3'd0;
      op_a_r      <= 16'd0;
      op_b_r      <= 16'd0;
      cnt_r       <= 5'd0;
      acc_r       <= 32'd0;
      mcand_r     <= 32'd0;
      mplier_r    <= 17'd0;
      neg_r       <= 1'b0;
      shw_r       <= 16'd0;
      result_r    <= 32'd0;
      is_ovf_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      opcode_r    <= opcode_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      mcand_r     <= mcand_s;
      mplier_r    <= mplier_s;
      neg_r       <= neg_s;
      shw_r       <= shw_s;
      result_r    <= result_s;
      is_ovf_r    <= is_ovf_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu.
// It runs directed cases, a backpressure case, a mid-operation reset,
// and 70 random operations.
// Every response is compared with an arithmetic reference model.
module tb_seq_alu;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_alu_if bus ();

  seq_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares an observed value with the expected value.
  // A mismatch is counted and reported.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model written directly from the operation rules.
  // Returns the result, the overflow flag, and the number of steps.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] res, output logic ovf, output int n);
    int          sa;
    int          sb;
    int          r;
    int          sh;
    logic [15:0] w;
    sa  = $signed(a);
    sb  = $signed(b);
    sh  = (b >= 16'd16) ? 16 : int'(b);
    res = 32'd0;
    ovf = 1'b0;
    n   = 0;
    w   = 16'd0;
    case (op)
      3'd0: begin r = sa + sb; res = r; ovf = (r > 32767) || (r < -32768); end
      3'd1: begin r = sa - sb; res = r; ovf = (r > 32767) || (r < -32768); end
      3'd2: begin r = sa * sb; res = r; n = 16; end
      3'd3, 3'd5: begin w = a << sh; res = {{16{w[15]}}, w}; n = sh; end
      3'd4: begin w = a >> sh; res = {{16{w[15]}}, w}; n = sh; end
      3'd6: begin w = $signed(a) >>> sh; res = {{16{w[15]}}, w}; n = sh; end
      default: begin res = 32'd0; n = 0; end
    endcase
  endtask

  // Runs one transaction and checks latency, result, flag and handshake.
  // If stall > 0, out_ready is held low for that many cycles
  // while a stray request is pulsed.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int stall);
    logic [31:0] exp_res;
    logic        exp_ovf;
    int          n;
    int          edges;
    logic        seen;
    model(op, a, b, exp_res, exp_ovf, n);
    @(negedge clk);
    bus.out_ready = (stall == 0) ? 1'b1 : 1'b0;
    check({tag, "/in_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_A     = a;
    bus.in_B     = b;
    bus.opcode   = op;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      seen = bus.out_valid;
    end
    check({tag, "/out_valid_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "/latency_edges"}, edges, 1 + n);
    check({tag, "/result"}, bus.result, exp_res);
    check({tag, "/is_ovf"}, {31'd0, bus.is_ovf}, {31'd0, exp_ovf});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.opcode   = 3'd0;
        bus.in_A     = 16'd1;
        bus.in_B     = 16'd1;
      end else begin
        bus.in_valid = 1'b0;
      end
      check({tag, "/stall_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "/stall_result"}, bus.result, exp_res);
      check({tag, "/stall_is_ovf"}, {31'd0, bus.is_ovf}, {31'd0, exp_ovf});
      check({tag, "/stall_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    if (stall > 0) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "/in_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "/out_valid_after"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_A      = 16'd0;
    bus.in_B      = 16'd0;
    bus.opcode    = 3'd0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset/in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset/out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset/result", bus.result, 32'd0);
    check("reset/is_ovf", {31'd0, bus.is_ovf}, 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op("add_ovf_pos", 3'd0, 16'h7FFF, 16'h0001, 0);
    run_op("add_ovf_neg", 3'd0, 16'h8000, 16'h8000, 0);
    run_op("sub_ovf_neg", 3'd1, 16'h8000, 16'h0001, 0);
    run_op("sub_ovf_pos", 3'd1, 16'h0001, 16'h8000, 0);
    run_op("sub_plain",   3'd1, 16'd5,    16'd3,    0);
    run_op("mul_minmin",  3'd2, 16'h8000, 16'h8000, 0);
    run_op("mul_3_m5",    3'd2, 16'd3,    16'hFFFB, 0);
    run_op("mul_zero",    3'd2, 16'd0,    16'h1234, 0);
    run_op("sra_4",       3'd6, 16'h8000, 16'd4,    0);
    run_op("srl_4",       3'd4, 16'h8000, 16'd4,    0);
    run_op("sll_15",      3'd3, 16'h0001, 16'd15,   0);
    run_op("sra_sat20",   3'd6, 16'h8000, 16'd20,   0);
    run_op("sll_0",       3'd3, 16'h8000, 16'd0,    0);
    run_op("sla_3",       3'd5, 16'h1234, 16'd3,    0);
    run_op("illegal",     3'd7, 16'h1234, 16'h5678, 0);

    // Backpressure, then an ordinary operation right after it
    run_op("bp_mul", 3'd2, 16'h0123, 16'hFF00, 5);
    run_op("bp_next_sub", 3'd1, 16'h4000, 16'hC000, 0);

    // Reset asserted in the middle of a multiply
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = 3'd2;
    bus.in_A     = 16'h00FF;
    bus.in_B     = 16'h00FF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst/out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst/result", bus.result, 32'd0);
    check("midrst/in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op("midrst_add", 3'd0, 16'd2, 16'd3, 0);

    // Random operations
    for (int k = 0; k < 70; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ((rop >= 3'd3) && (rop <= 3'd6) && ($urandom_range(0, 3) != 0)) begin
        rb = 16'($urandom_range(0, 20));
      end
      run_op("random", rop, ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
